// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline sequencing bus between the hazard/stall controller and the datapath.
interface hazard_stall_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             idex_mem_read;
    logic [4:0]       idex_rt;
    logic [1:0]       ex_pc_src;
    logic             ex_md_start;
    logic             cnt_clr;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_hold;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic             md_done;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    // Datapath side: supplies hazard inputs, consumes pipeline controls.
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, idex_mem_read, idex_rt,
               ex_pc_src, ex_md_start, cnt_clr,
        input  pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble,
               exmem_bubble, md_done, stall_cycles, flush_events
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, idex_mem_read, idex_rt,
               ex_pc_src, ex_md_start, cnt_clr,
        output pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble,
               exmem_bubble, md_done, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall sequencing for the 5-stage MIPS pipeline: load-use stalls,
// branch/jump squash, multiply/divide freeze, and saturating perf counters.
module hazard_stall_ctrl #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_ctrl_if.slave  bus
);

    localparam int unsigned          MD_CNT_W    = $clog2(MD_LATENCY);
    localparam logic [MD_CNT_W-1:0]  MD_CNT_LOAD = MD_CNT_W'(MD_LATENCY - 2);
    localparam logic [CNT_W-1:0]     CNT_MAX     = '1;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_BUSY = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]    flush_events_q, flush_events_d;

    logic freeze_c;
    logic redirect_c;
    logic load_use_c;
    logic lu_match_c;
    logic pc_write_c;
    logic ifid_write_c;
    logic ifid_flush_c;
    logic idex_hold_c;
    logic idex_bubble_c;
    logic exmem_bubble_c;
    logic md_done_c;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_RUN;
            md_cnt_q       <= '0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            md_cnt_q       <= md_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    // Next state and Mealy pipeline controls; freeze > redirect > load-use.
    always_comb begin
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;
        freeze_c       = 1'b0;
        md_done_c      = 1'b0;
        pc_write_c     = 1'b1;
        ifid_write_c   = 1'b1;
        ifid_flush_c   = 1'b0;
        idex_hold_c    = 1'b0;
        idex_bubble_c  = 1'b0;
        exmem_bubble_c = 1'b0;

        lu_match_c = bus.idex_mem_read && (bus.idex_rt != 5'd0) &&
                     ((bus.id_uses_rs && (bus.id_rs == bus.idex_rt)) ||
                      (bus.id_uses_rt && (bus.id_rt == bus.idex_rt)));

        case (state_q)
            ST_RUN: begin
                // A redirect in the same cycle cancels the multiply/divide.
                if (bus.ex_md_start && (bus.ex_pc_src == 2'd0)) begin
                    freeze_c = 1'b1;
                    state_d  = ST_MD_BUSY;
                    md_cnt_d = MD_CNT_LOAD;
                end
            end
            ST_MD_BUSY: begin
                if (md_cnt_q != '0) begin
                    freeze_c = 1'b1;
                    md_cnt_d = md_cnt_q - MD_CNT_W'(1);
                end else begin
                    md_done_c = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        redirect_c = !freeze_c && (bus.ex_pc_src != 2'd0);
        load_use_c = !freeze_c && !redirect_c && lu_match_c;

        if (freeze_c) begin
            pc_write_c     = 1'b0;
            ifid_write_c   = 1'b0;
            idex_hold_c    = 1'b1;
            exmem_bubble_c = 1'b1;
        end else if (redirect_c) begin
            ifid_flush_c   = 1'b1;
            idex_bubble_c  = 1'b1;
        end else if (load_use_c) begin
            pc_write_c     = 1'b0;
            ifid_write_c   = 1'b0;
            idex_bubble_c  = 1'b1;
        end

        // Controls sit at their idle values while reset is held.
        if (!rst) begin
            pc_write_c     = 1'b1;
            ifid_write_c   = 1'b1;
            ifid_flush_c   = 1'b0;
            idex_hold_c    = 1'b0;
            idex_bubble_c  = 1'b0;
            exmem_bubble_c = 1'b0;
            md_done_c      = 1'b0;
        end
    end

    // Saturating performance counters; clear beats increment.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (bus.cnt_clr) begin
            stall_cycles_d = '0;
            flush_events_d = '0;
        end else begin
            if (!pc_write_c && (stall_cycles_q != CNT_MAX)) begin
                stall_cycles_d = stall_cycles_q + CNT_W'(1);
            end
            if (ifid_flush_c && (flush_events_q != CNT_MAX)) begin
                flush_events_d = flush_events_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_write     = pc_write_c;
    assign bus.ifid_write   = ifid_write_c;
    assign bus.ifid_flush   = ifid_flush_c;
    assign bus.idex_hold    = idex_hold_c;
    assign bus.idex_bubble  = idex_bubble_c;
    assign bus.exmem_bubble = exmem_bubble_c;
    assign bus.md_done      = md_done_c;
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one instance with MD_LATENCY=4/CNT_W=32,
// one with MD_LATENCY=2/CNT_W=4, sharing all hazard inputs except ex_md_start.
module tb_hazard_stall_ctrl;

    // Control vector order: pc_write, ifid_write, ifid_flush, idex_hold,
    // idex_bubble, exmem_bubble, md_done.
    localparam logic [6:0] V_DEF  = 7'b1100000;
    localparam logic [6:0] V_LU   = 7'b0000100;
    localparam logic [6:0] V_RD   = 7'b1110100;
    localparam logic [6:0] V_FRZ  = 7'b0001010;
    localparam logic [6:0] V_DONE = 7'b1100001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [4:0] s_id_rs, s_id_rt, s_idex_rt;
    logic       s_uses_rs, s_uses_rt, s_mem_rd, s_cnt_clr;
    logic [1:0] s_pc_src;
    logic       s_md_a, s_md_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.CNT_W(32)) if_a ();
    hazard_stall_ctrl_if #(.CNT_W(4))  if_b ();

    assign if_a.id_rs         = s_id_rs;
    assign if_a.id_rt         = s_id_rt;
    assign if_a.id_uses_rs    = s_uses_rs;
    assign if_a.id_uses_rt    = s_uses_rt;
    assign if_a.idex_mem_read = s_mem_rd;
    assign if_a.idex_rt       = s_idex_rt;
    assign if_a.ex_pc_src     = s_pc_src;
    assign if_a.ex_md_start   = s_md_a;
    assign if_a.cnt_clr       = s_cnt_clr;

    assign if_b.id_rs         = s_id_rs;
    assign if_b.id_rt         = s_id_rt;
    assign if_b.id_uses_rs    = s_uses_rs;
    assign if_b.id_uses_rt    = s_uses_rt;
    assign if_b.idex_mem_read = s_mem_rd;
    assign if_b.idex_rt       = s_idex_rt;
    assign if_b.ex_pc_src     = s_pc_src;
    assign if_b.ex_md_start   = s_md_b;
    assign if_b.cnt_clr       = s_cnt_clr;

    hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(32)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    hazard_stall_ctrl #(.MD_LATENCY(2), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    wire [6:0] ctrl_a = {if_a.pc_write, if_a.ifid_write, if_a.ifid_flush, if_a.idex_hold,
                         if_a.idex_bubble, if_a.exmem_bubble, if_a.md_done};
    wire [6:0] ctrl_b = {if_b.pc_write, if_b.ifid_write, if_b.ifid_flush, if_b.idex_hold,
                         if_b.idex_bubble, if_b.exmem_bubble, if_b.md_done};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        s_id_rs   = 5'd0;
        s_id_rt   = 5'd0;
        s_idex_rt = 5'd0;
        s_uses_rs = 1'b0;
        s_uses_rt = 1'b0;
        s_mem_rd  = 1'b0;
        s_pc_src  = 2'd0;
        s_md_a    = 1'b0;
        s_md_b    = 1'b0;
        s_cnt_clr = 1'b0;
    endtask

    task automatic load_use_rs(input logic [4:0] r);
        s_mem_rd  = 1'b1;
        s_idex_rt = r;
        s_id_rs   = r;
        s_uses_rs = 1'b1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with random inputs: controls idle, counters cleared.
        s_id_rs   = 5'($urandom);
        s_id_rt   = 5'($urandom);
        s_idex_rt = 5'($urandom);
        s_uses_rs = 1'b1;
        s_uses_rt = 1'b1;
        s_mem_rd  = 1'b1;
        s_pc_src  = 2'($urandom);
        s_md_a    = 1'b1;
        s_md_b    = 1'b1;
        s_cnt_clr = 1'b0;
        #2;
        check_eq("rst_ctrl_a", 32'(ctrl_a), 32'(V_DEF));
        check_eq("rst_ctrl_b", 32'(ctrl_b), 32'(V_DEF));
        tick();
        tick();
        idle();
        rst = 1'b1;
        #1;
        check_eq("post_rst_ctrl_a", 32'(ctrl_a), 32'(V_DEF));
        check_eq("post_rst_stall_a", if_a.stall_cycles, 32'd0);
        check_eq("post_rst_flush_a", if_a.flush_events, 32'd0);
        check_eq("post_rst_stall_b", 32'(if_b.stall_cycles), 32'd0);

        // Load-use via Rs: one stall cycle.
        tick();
        load_use_rs(5'd8);
        #1 check_eq("lu_rs_ctrl", 32'(ctrl_a), 32'(V_LU));
        tick();
        idle();
        #1 check_eq("lu_clear_ctrl", 32'(ctrl_a), 32'(V_DEF));
        check_eq("lu_stall_cnt", if_a.stall_cycles, 32'd1);

        // Load into $0 never stalls.
        load_use_rs(5'd0);
        #1 check_eq("lu_r0_ctrl", 32'(ctrl_a), 32'(V_DEF));
        tick();
        idle();
        #1 check_eq("lu_r0_stall_cnt", if_a.stall_cycles, 32'd1);

        // Load-use via Rt.
        s_mem_rd  = 1'b1;
        s_idex_rt = 5'd5;
        s_id_rt   = 5'd5;
        s_uses_rt = 1'b1;
        #1 check_eq("lu_rt_ctrl", 32'(ctrl_a), 32'(V_LU));
        tick();
        // Matching Rs but Rs not read: no stall.
        idle();
        s_mem_rd  = 1'b1;
        s_idex_rt = 5'd9;
        s_id_rs   = 5'd9;
        #1 check_eq("lu_unused_rs_ctrl", 32'(ctrl_a), 32'(V_DEF));
        tick();
        idle();
        #1 check_eq("lu_rt_stall_cnt", if_a.stall_cycles, 32'd2);

        // Redirect alone.
        s_pc_src = 2'b01;
        #1 check_eq("rd_ctrl", 32'(ctrl_a), 32'(V_RD));
        tick();
        idle();
        #1 check_eq("rd_flush_cnt", if_a.flush_events, 32'd1);

        // Redirect beats a simultaneous load-use.
        s_pc_src = 2'b10;
        load_use_rs(5'd8);
        #1 check_eq("rd_over_lu_ctrl", 32'(ctrl_a), 32'(V_RD));
        tick();
        idle();
        #1 check_eq("rd_over_lu_flush", if_a.flush_events, 32'd2);
        check_eq("rd_over_lu_stall", if_a.stall_cycles, 32'd2);

        // MD_LATENCY=4: three freeze cycles then md_done.
        s_md_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check_eq($sformatf("md4_cyc%0d", i), 32'(ctrl_a), 32'(i < 3 ? V_FRZ : V_DONE));
            tick();
        end
        s_md_a = 1'b0;
        #1 check_eq("md4_after_ctrl", 32'(ctrl_a), 32'(V_DEF));
        check_eq("md4_stall_cnt", if_a.stall_cycles, 32'd5);

        // MD_LATENCY=2: one freeze cycle then md_done.
        s_md_b = 1'b1;
        #1 check_eq("md2_cyc0", 32'(ctrl_b), 32'(V_FRZ));
        tick();
        #1 check_eq("md2_cyc1", 32'(ctrl_b), 32'(V_DONE));
        tick();
        s_md_b = 1'b0;
        #1 check_eq("md2_after_ctrl", 32'(ctrl_b), 32'(V_DEF));
        check_eq("md2_stall_cnt", 32'(if_b.stall_cycles), 32'd3);

        // Illegal md_start with redirect: redirect only, no freeze next cycle.
        s_md_a   = 1'b1;
        s_pc_src = 2'b01;
        #1 check_eq("illegal_ctrl", 32'(ctrl_a), 32'(V_RD));
        tick();
        idle();
        #1 check_eq("illegal_next_ctrl", 32'(ctrl_a), 32'(V_DEF));
        check_eq("illegal_flush_cnt", if_a.flush_events, 32'd3);

        // Reset one cycle into MD_BUSY.
        s_md_a = 1'b1;
        tick();
        #1 check_eq("midrst_busy_ctrl", 32'(ctrl_a), 32'(V_FRZ));
        rst    = 1'b0;
        s_md_a = 1'b0;
        #1 check_eq("midrst_async_ctrl", 32'(ctrl_a), 32'(V_DEF));
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check_eq($sformatf("midrst_nodone%0d", i), 32'(ctrl_a), 32'(V_DEF));
            tick();
        end
        check_eq("midrst_stall_cnt", if_a.stall_cycles, 32'd0);

        // Saturation of the 4-bit counter under a held load-use hazard.
        load_use_rs(5'd12);
        for (int i = 0; i < 20; i++) tick();
        check_eq("sat_stall_b", 32'(if_b.stall_cycles), 32'd15);
        check_eq("sat_stall_a", if_a.stall_cycles, 32'd20);

        // Clear wins over a same-cycle increment.
        s_cnt_clr = 1'b1;
        tick();
        idle();
        #1 check_eq("clr_stall_b", 32'(if_b.stall_cycles), 32'd0);
        check_eq("clr_stall_a", if_a.stall_cycles, 32'd0);
        check_eq("clr_flush_a", if_a.flush_events, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It drives the enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects load-use hazards against the ID/EX stage.
- Squashes wrong-path instructions when EX resolves a taken branch or jump.
- Freezes the front end for the duration of a multi-cycle multiply/divide in EX.
- Keeps saturating counters of stall cycles and flush events for performance analysis.

Parameters:
MD_LATENCY, 4, total EX-stage cycles of a multiply/divide op; legal range 2..16
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  core clock; all state updates on its rising edge
rst  input  1  asynchronous, active-low reset
id_rs  input  5  Rs field of the instruction in ID
id_rt  input  5  Rt field of the instruction in ID
id_uses_rs  input  1  ID instruction reads Rs
id_uses_rt  input  1  ID instruction reads Rt
idex_mem_read  input  1  MemRead output of the ID/EX register
idex_rt  input  5  Rt output of the ID/EX register (load destination)
ex_pc_src  input  2  PCSrc output of the ID/EX register, qualified by branch outcome; nonzero means redirect
ex_md_start  input  1  the instruction in EX is a multiply/divide
cnt_clr  input  1  synchronous clear of both counters
pc_write  output  1  PC register enable
ifid_write  output  1  IF/ID register enable
ifid_flush  output  1  load a NOP into IF/ID
idex_hold  output  1  ID/EX register keeps its contents
idex_bubble  output  1  load zeros into ID/EX control fields
exmem_bubble  output  1  load zeros into EX/MEM control fields
md_done  output  1  multiply/divide result valid in EX this cycle
stall_cycles  output  CNT_W  count of cycles with pc_write=0
flush_events  output  CNT_W  count of cycles with ifid_flush=1

Behaviour:
Reset and general rules
- Reset is asynchronous, active-low (rst=0): state=RUN, md_cnt=0, both counters 0.
- Control outputs are combinational (Mealy) from state and inputs, so a stall or flush takes effect in the same cycle.
- With no hazard inputs active, the outputs are pc_write=1, ifid_write=1, and all others 0. These values also hold while rst=0.

States
- RUN and MD_BUSY.
- md_cnt is a down-counter of width clog2(MD_LATENCY).

Priority when several conditions are active: freeze > redirect > load-use.

Freeze (multiply/divide)
- Active when (state=RUN and ex_md_start=1 and ex_pc_src=0), or (state=MD_BUSY and md_cnt!=0).
- Outputs: pc_write=0, ifid_write=0, idex_hold=1, exmem_bubble=1.
- RUN with freeze: next state=MD_BUSY, md_cnt<=MD_LATENCY-2.
- MD_BUSY with md_cnt!=0: md_cnt decrements; ex_md_start is ignored because ID/EX is held.
- MD_BUSY with md_cnt=0: no freeze, md_done=1, next state=RUN. Redirect and load-use detection apply normally in this cycle.
- Total freeze cycles = MD_LATENCY-1. EX occupancy = MD_LATENCY cycles.

Redirect
- Active when ex_pc_src!=0 and there is no freeze.
- Outputs: ifid_flush=1, idex_bubble=1, pc_write=1.
- Lasts one cycle per taken branch.
- If ex_md_start=1 and ex_pc_src!=0 together (illegal encoding), redirect wins and no multiply/divide starts.

Load-use
- Active when idex_mem_read=1, idex_rt!=0, and either (id_uses_rs=1 and id_rs=idex_rt) or (id_uses_rt=1 and id_rt=idex_rt).
- Applies only with no freeze and no redirect.
- Outputs: pc_write=0, ifid_write=0, idex_bubble=1, lasting one cycle.
- On the next cycle idex_mem_read is 0 (bubble), so the stall self-clears.
- Register $0 never triggers a load-use stall.

Counters
- stall_cycles increments each cycle pc_write=0.
- flush_events increments each cycle ifid_flush=1.
- Both saturate at 2^CNT_W-1; there is no wrap.
- cnt_clr=1 zeroes both counters on the next edge and takes priority over increment.

Reset mid-operation
- Reset asserted in MD_BUSY returns the block immediately to RUN and releases the freeze.

Test Plan:
1. Reset: rst=0 with random inputs, then release → pc_write=1, ifid_write=1, all other control outputs 0, both counters 0.
2. Load-use: idex_mem_read=1, idex_rt=8, id_rs=8, id_uses_rs=1 → exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles=1. Same stimulus with idex_rt=0 → no stall.
3. Redirect: ex_pc_src=2'b01 for one cycle → ifid_flush=1, idex_bubble=1, pc_write=1; flush_events=1. Load-use asserted in the same cycle → pc_write stays 1.
4. Multiply/divide with MD_LATENCY=4: ex_md_start=1 held → freeze outputs for 3 cycles, md_done=1 on the 4th, then RUN; stall_cycles=3. Repeat with MD_LATENCY=2 → 1 freeze cycle.
5. Reset mid-op: assert rst=0 one cycle into MD_BUSY → outputs return to defaults asynchronously; after release no md_done appears.
6. Counter saturation with CNT_W=4: hold a load-use hazard for 20 cycles → stall_cycles stops at 15. Then cnt_clr=1 → 0 next cycle.
